// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the frame counter width helper.
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Enough bits to hold a count from 0 up to and including the register length.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_frame_cnt.sv
// Frame tracker: counts shifts since the last load, holds busy through the
// frame and pulses frame_done for one cycle after the WIDTH-th shift.
module shift_frame_cnt
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic shift,
  output logic busy,
  output logic frame_done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count;

  // A load always wins over a shift; shifts outside a frame leave the counter alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (load) begin
        count <= '0;
        busy  <= 1'b1;
      end else if (shift && busy) begin
        if (count == LAST) begin
          count      <= '0;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end else begin
          count <= count + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register (hold / shift right / shift left / parallel load)
// with frame tracking. Defining SHIFT_REG_ROTATE_EN adds a rot input.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             sin,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic             rot,
`endif
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             frame_done
);

  logic in_r;
  logic in_l;
  logic load;
  logic shift;

  // Rotation feeds the outgoing bit back in at the opposite end.
  always_comb begin
`ifdef SHIFT_REG_ROTATE_EN
    in_r = rot ? pout[0]       : sin;
    in_l = rot ? pout[WIDTH-1] : sin;
`else
    in_r = sin;
    in_l = sin;
`endif
  end

  assign load   = (mode == MODE_LOAD);
  assign shift  = (mode == MODE_SHR) || (mode == MODE_SHL);
  assign sout_r = pout[0];
  assign sout_l = pout[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      pout <= RST_VAL;
    end else begin
      case (mode)
        MODE_SHR:  pout <= {in_r, pout[WIDTH-1:1]};
        MODE_SHL:  pout <= {pout[WIDTH-2:0], in_l};
        MODE_LOAD: pout <= pin;
        default:   pout <= pout;
      endcase
    end
  end

  shift_frame_cnt #(
    .WIDTH(WIDTH)
  ) u_frame_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .shift      (shift),
    .busy       (busy),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed self-checking bench for shift_reg_univ (WIDTH=8, RST_VAL=8'hA5).
// Rotation scenario is compiled in only when SHIFT_REG_ROTATE_EN is defined.
module tb_shift_reg_univ;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       sin;
`ifdef SHIFT_REG_ROTATE_EN
  logic       rot;
`endif
  logic [7:0] pin;
  logic [7:0] pout;
  logic       sout_r;
  logic       sout_l;
  logic       busy;
  logic       frame_done;

  int errors;
  int checks;

  shift_reg_univ #(
    .WIDTH   (8),
    .RST_VAL (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .sin        (sin),
`ifdef SHIFT_REG_ROTATE_EN
    .rot        (rot),
`endif
    .pin        (pin),
    .pout       (pout),
    .sout_r     (sout_r),
    .sout_l     (sout_l),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'b00; sin = 1'b0; pin = 8'h00;
    tick();
    tick();
    checks++; if (pout !== 8'hA5) begin errors++; $display("[TB] FAIL reset_pout got=%h exp=%h", pout, 8'hA5); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", frame_done); end
    checks++; if (sout_r !== 1'b1) begin errors++; $display("[TB] FAIL reset_sout_r got=%b exp=1", sout_r); end
    checks++; if (sout_l !== 1'b1) begin errors++; $display("[TB] FAIL reset_sout_l got=%b exp=1", sout_l); end
    rst = 1'b0;
  endtask

  task automatic test_piso_right();
    logic [7:0] exp_bits;
    exp_bits = 8'b1011_0100;
    mode = 2'b11; pin = 8'hB4;
    tick();
    checks++; if (pout !== 8'hB4 || busy !== 1'b1) begin errors++; $display("[TB] FAIL piso_load got=%h/%b exp=b4/1", pout, busy); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (sout_r !== exp_bits[i]) begin errors++; $display("[TB] FAIL piso_sout_r[%0d] got=%b exp=%b", i, sout_r, exp_bits[i]); end
      mode = 2'b01; sin = 1'b0;
      tick();
      checks++;
      if (i < 7) begin
        if (busy !== 1'b1 || frame_done !== 1'b0) begin errors++; $display("[TB] FAIL piso_mid[%0d] busy=%b done=%b exp busy=1 done=0", i, busy, frame_done); end
      end else begin
        if (busy !== 1'b0 || frame_done !== 1'b1) begin errors++; $display("[TB] FAIL piso_end busy=%b done=%b exp busy=0 done=1", busy, frame_done); end
      end
    end
    mode = 2'b00;
    tick();
    checks++; if (pout !== 8'h00 || frame_done !== 1'b0) begin errors++; $display("[TB] FAIL piso_after pout=%h done=%b exp=00/0", pout, frame_done); end
  endtask

  task automatic test_sipo_left();
    logic [7:0] bits;
    bits = 8'b1011_0010;
    rst = 1'b1; mode = 2'b00;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mode = 2'b10; sin = bits[7-i];
      tick();
      checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("[TB] FAIL sipo_flags[%0d] busy=%b done=%b exp=0/0", i, busy, frame_done); end
    end
    checks++; if (pout !== 8'hB2) begin errors++; $display("[TB] FAIL sipo_pout got=%h exp=b2", pout); end
    mode = 2'b00;
  endtask

  task automatic test_hold_restart();
    int pulses;
    mode = 2'b11; pin = 8'hFF;
    tick();
    for (int i = 0; i < 3; i++) begin
      mode = 2'b10; sin = 1'b0;
      tick();
    end
    checks++; if (pout !== 8'hF8) begin errors++; $display("[TB] FAIL hold_pre got=%h exp=f8", pout); end
    for (int i = 0; i < 2; i++) begin
      mode = 2'b00;
      tick();
      checks++; if (pout !== 8'hF8 || busy !== 1'b1 || frame_done !== 1'b0) begin errors++; $display("[TB] FAIL hold[%0d] pout=%h busy=%b done=%b exp=f8/1/0", i, pout, busy, frame_done); end
    end
    mode = 2'b11; pin = 8'h0F;
    tick();
    checks++; if (pout !== 8'h0F || busy !== 1'b1) begin errors++; $display("[TB] FAIL reload got=%h/%b exp=0f/1", pout, busy); end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      mode = 2'b01; sin = 1'b1;
      tick();
      if (frame_done === 1'b1) pulses++;
      checks++; if (frame_done !== (i == 7)) begin errors++; $display("[TB] FAIL restart_done[%0d] got=%b exp=%b", i, frame_done, (i == 7)); end
    end
    checks++; if (pulses != 1 || pout !== 8'hFF) begin errors++; $display("[TB] FAIL restart_end pulses=%0d pout=%h exp=1/ff", pulses, pout); end
    mode = 2'b00;
    tick();
  endtask

  task automatic test_mixed();
    mode = 2'b11; pin = 8'h81;
    tick();
    for (int i = 0; i < 8; i++) begin
      mode = (i < 4) ? 2'b01 : 2'b10; sin = 1'b0;
      tick();
      checks++; if (frame_done !== (i == 7)) begin errors++; $display("[TB] FAIL mixed_done[%0d] got=%b exp=%b", i, frame_done, (i == 7)); end
    end
    checks++; if (pout !== 8'h80 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mixed_end pout=%h busy=%b exp=80/0", pout, busy); end
    mode = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    mode = 2'b11; pin = 8'h3C;
    tick();
    for (int i = 0; i < 4; i++) begin
      mode = 2'b01; sin = 1'b0;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (pout !== 8'hA5 || busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("[TB] FAIL midrst pout=%h busy=%b done=%b exp=a5/0/0", pout, busy, frame_done); end
    for (int i = 0; i < 8; i++) begin
      mode = 2'b01; sin = 1'b0;
      tick();
      checks++; if (frame_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_after[%0d] done=%b busy=%b exp=0/0", i, frame_done, busy); end
    end
    mode = 2'b00;
  endtask

`ifdef SHIFT_REG_ROTATE_EN
  task automatic test_rotate();
    mode = 2'b11; pin = 8'h81; rot = 1'b1;
    tick();
    mode = 2'b01; sin = 1'b0;
    tick();
    checks++; if (pout !== 8'hC0) begin errors++; $display("[TB] FAIL rot_first got=%h exp=c0", pout); end
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++; if (frame_done !== (i == 7)) begin errors++; $display("[TB] FAIL rot_done[%0d] got=%b exp=%b", i, frame_done, (i == 7)); end
    end
    checks++; if (pout !== 8'h81) begin errors++; $display("[TB] FAIL rot_end got=%h exp=81", pout); end
    mode = 2'b00; rot = 1'b0;
    tick();
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
`ifdef SHIFT_REG_ROTATE_EN
    rot = 1'b0;
`endif
    test_reset();
    test_piso_right();
    test_sipo_left();
    test_hold_restart();
    test_mixed();
    test_reset_mid_frame();
`ifdef SHIFT_REG_ROTATE_EN
    test_rotate();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
